// File: rtl/tx_relatorio_elevador_pkg.sv
// Shared constants, state encodings and byte builders for the elevator status reporter.
// The TX_CHECKSUM_EN macro adds the CHECKSUM state encoding.
package tx_relatorio_elevador_pkg;

  localparam int BAUD_PADRAO = 434;

  localparam logic [1:0] MARCA_CABECALHO = 2'b11;
  localparam logic [1:0] MARCA_SLOT      = 2'b01;

  typedef enum logic [3:0] {
    REPOUSO      = 4'd0,
    CABECALHO    = 4'd1,
    PREP_SLOT    = 4'd2,
    CARREGA_SLOT = 4'd3,
    ESPERA_TX    = 4'd4,
`ifdef TX_CHECKSUM_EN
    CHECKSUM     = 4'd5,
`endif
    FIM          = 4'd6
  } estado_t;

  typedef enum logic [1:0] {
    UART_OCIOSO = 2'd0,
    UART_INICIO = 2'd1,
    UART_DADOS  = 2'd2,
    UART_PARADA = 2'd3
  } estado_uart_t;

  function automatic logic [7:0] montaCabecalho(input logic [1:0] andar);
    return {MARCA_CABECALHO, 4'b0000, andar};
  endfunction

  // Only the two low index bits travel in the byte, mirroring the receiver format.
  function automatic logic [7:0] montaSlot(input logic [1:0] tipo,
                                           input logic [1:0] destino,
                                           input logic [4:0] indice);
    return {MARCA_SLOT, tipo, destino, indice[1:0]};
  endfunction

endpackage

// File: rtl/tx_relatorio_elevador_if.sv
// Request/status bundle of the elevator status reporter: request, floor, contents RAM
// read port, serial line and status flags.
interface tx_relatorio_elevador_if;
  logic       enviar;
  logic [1:0] andar_atual;
  logic [1:0] slot_tipo;
  logic [1:0] slot_destino;
  logic [3:0] slot_addr;
  logic       TX;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output enviar, andar_atual, slot_tipo, slot_destino,
    input  slot_addr, TX, ocupado, pronto, db_estado
  );

  modport slave (
    input  enviar, andar_atual, slot_tipo, slot_destino,
    output slot_addr, TX, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/tx_relatorio_elevador_tx_serial.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held CLKS_PER_BIT cycles by a down-counting bit timer.
module tx_serial_8N1
  import tx_relatorio_elevador_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] CARGA = TW'(CLKS_PER_BIT - 1);

  estado_uart_t  estadoUart;
  logic [TW-1:0] timer;
  logic [2:0]    indiceBit;
  logic [7:0]    registro;

  // Done is decoded during the final stop-bit cycle so the caller can react on that same edge.
  assign pronto = (estadoUart == UART_PARADA) && (timer == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoUart   <= UART_OCIOSO;
      timer        <= '0;
      indiceBit    <= '0;
      registro     <= '0;
      saida_serial <= 1'b1;
    end else begin
      case (estadoUart)
        UART_OCIOSO: begin
          saida_serial <= 1'b1;
          if (partida) begin
            registro     <= dados;
            saida_serial <= 1'b0;
            timer        <= CARGA;
            estadoUart   <= UART_INICIO;
          end
        end
        UART_INICIO: begin
          if (timer == '0) begin
            saida_serial <= registro[0];
            indiceBit    <= '0;
            timer        <= CARGA;
            estadoUart   <= UART_DADOS;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        UART_DADOS: begin
          if (timer == '0) begin
            timer <= CARGA;
            if (indiceBit == 3'd7) begin
              saida_serial <= 1'b1;
              estadoUart   <= UART_PARADA;
            end else begin
              registro     <= {1'b0, registro[7:1]};
              saida_serial <= registro[1];
              indiceBit    <= indiceBit + 3'd1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        UART_PARADA: begin
          if (timer == '0) begin
            estadoUart <= UART_OCIOSO;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: estadoUart <= UART_OCIOSO;
      endcase
    end
  end

endmodule

// File: rtl/tx_relatorio_elevador.sv
// Elevator status reporter: on request sends a floor header plus one byte per contents slot
// over an 8N1 link. Define TX_CHECKSUM_EN to append an XOR checksum byte to each frame.
//
// state        | meaning
// REPOUSO      | idle, waiting for enviar
// CABECALHO    | load header byte, start UART
// PREP_SLOT    | present slot_addr to the contents RAM
// CARREGA_SLOT | sample slot data, build slot byte, start UART
// ESPERA_TX    | wait for UART done, pick next byte
// CHECKSUM     | load accumulated XOR, start UART (TX_CHECKSUM_EN only)
// FIM          | pronto high for this cycle, back to REPOUSO
module tx_relatorio_elevador
  import tx_relatorio_elevador_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_PADRAO,
  parameter int N_SLOTS      = 4
) (
  input logic               clock,
  input logic               reset,
  tx_relatorio_elevador_if.slave bus
);

  localparam logic [4:0] LIMITE = 5'(N_SLOTS);

  estado_t    estado;
  logic [1:0] andarLatch;
  logic [4:0] contSlot;
  logic       partidaUart;
  logic [7:0] byteUart;
  logic       fimUart;
  logic       saidaUart;
  logic       ocupadoReg;
  logic       prontoReg;
`ifdef TX_CHECKSUM_EN
  logic [7:0] acumulador;
  logic       checksumEnviado;
`endif

  tx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) uart (
    .clock        (clock),
    .reset        (reset),
    .partida      (partidaUart),
    .dados        (byteUart),
    .saida_serial (saidaUart),
    .pronto       (fimUart)
  );

  assign bus.slot_addr = contSlot[3:0];
  assign bus.TX        = saidaUart;
  assign bus.ocupado   = ocupadoReg;
  assign bus.pronto    = prontoReg;
  assign bus.db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= REPOUSO;
      andarLatch  <= '0;
      contSlot    <= '0;
      partidaUart <= 1'b0;
      byteUart    <= '0;
      ocupadoReg  <= 1'b0;
      prontoReg   <= 1'b0;
`ifdef TX_CHECKSUM_EN
      acumulador      <= '0;
      checksumEnviado <= 1'b0;
`endif
    end else begin
      partidaUart <= 1'b0;
      prontoReg   <= 1'b0;
      case (estado)
        REPOUSO: begin
          if (bus.enviar) begin
            andarLatch <= bus.andar_atual;
            contSlot   <= '0;
            ocupadoReg <= 1'b1;
`ifdef TX_CHECKSUM_EN
            acumulador      <= '0;
            checksumEnviado <= 1'b0;
`endif
            estado <= CABECALHO;
          end
        end
        CABECALHO: begin
          byteUart    <= montaCabecalho(andarLatch);
          partidaUart <= 1'b1;
`ifdef TX_CHECKSUM_EN
          acumulador <= acumulador ^ montaCabecalho(andarLatch);
`endif
          estado <= ESPERA_TX;
        end
        PREP_SLOT: estado <= CARREGA_SLOT;
        CARREGA_SLOT: begin
          byteUart    <= montaSlot(bus.slot_tipo, bus.slot_destino, contSlot);
          partidaUart <= 1'b1;
          contSlot    <= contSlot + 5'd1;
`ifdef TX_CHECKSUM_EN
          acumulador <= acumulador ^ montaSlot(bus.slot_tipo, bus.slot_destino, contSlot);
`endif
          estado <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (fimUart) begin
            if (contSlot < LIMITE) begin
              estado <= PREP_SLOT;
            end
`ifdef TX_CHECKSUM_EN
            else if (!checksumEnviado) begin
              estado <= CHECKSUM;
            end
`endif
            else begin
              // pronto and ocupado switch on the edge that ends the last stop bit
              estado     <= FIM;
              prontoReg  <= 1'b1;
              ocupadoReg <= 1'b0;
            end
          end
        end
`ifdef TX_CHECKSUM_EN
        CHECKSUM: begin
          byteUart        <= acumulador;
          partidaUart     <= 1'b1;
          checksumEnviado <= 1'b1;
          estado          <= ESPERA_TX;
        end
`endif
        FIM:     estado <= REPOUSO;
        default: estado <= REPOUSO;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_relatorio_elevador.sv
// Scoreboard bench for tx_relatorio_elevador: stimulus queues expected bytes and frame ends,
// a serial decoder pops and compares them. Honors TX_CHECKSUM_EN like the design.
`timescale 1ns/1ps
module tb_tx_relatorio_elevador;

  localparam int CPB     = 4;
  localparam int FIM_Q   = 256;
`ifdef TX_CHECKSUM_EN
  localparam int NBYTES  = 6;
`else
  localparam int NBYTES  = 5;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_relatorio_elevador_if bus();

  tx_relatorio_elevador #(.CLKS_PER_BIT(CPB), .N_SLOTS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] tipoMem    [16];
  logic [1:0] destinoMem [16];
  assign bus.slot_tipo    = tipoMem[bus.slot_addr];
  assign bus.slot_destino = destinoMem[bus.slot_addr];

  int checks = 0;
  int errors = 0;
  int esperado[$];
  int prontoCount = 0;
  int bytesDecoded = 0;
  bit dentroQuadro = 0;

  task automatic checkVal(input string nome, input int atual, input int req);
    checks++;
    if (atual != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, req);
    end
  endtask

  always @(negedge clock) if (reset === 1'b0 && bus.pronto === 1'b1) prontoCount++;

  // Serial decoder / scoreboard consumer
  initial begin : monitor
    logic [39:0] amostras;
    logic [7:0]  dado;
    bit abortado;
    bit ok;
    int ocioso;
    ocioso = 0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b0) begin dentroQuadro = 0; ocioso = 0; continue; end
      if (bus.TX !== 1'b0) begin ocioso++; continue; end
      if (dentroQuadro) checkVal("inter_byte_gap_le3", (ocioso <= 3) ? 1 : 0, 1);
      amostras = '0;
      amostras[0] = bus.TX;
      abortado = 0;
      for (int n = 1; n < 40; n++) begin
        @(negedge clock);
        if (reset !== 1'b0) begin abortado = 1; break; end
        amostras[n] = bus.TX;
      end
      ocioso = 0;
      if (abortado) begin dentroQuadro = 0; continue; end
      ok = 1;
      for (int b = 0; b < 10; b++)
        for (int s = 1; s < CPB; s++)
          if (amostras[CPB*b+s] !== amostras[CPB*b]) ok = 0;
      for (int d = 0; d < 8; d++) dado[d] = amostras[CPB*(d+1)];
      checkVal("bit_duration", ok, 1);
      checkVal("stop_bit", amostras[36], 1);
      bytesDecoded++;
      if (esperado.size() == 0 || esperado[0] == FIM_Q) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %02h expected none", dado);
      end else begin
        checkVal("byte", dado, esperado.pop_front());
      end
      dentroQuadro = 1;
      if (esperado.size() > 0 && esperado[0] == FIM_Q) begin
        @(negedge clock);
        void'(esperado.pop_front());
        checkVal("pronto_after_stop", bus.pronto, 1);
        checkVal("ocupado_falls_with_pronto", bus.ocupado, 0);
        dentroQuadro = 0;
        ocioso = 1;
      end
    end
  end

  task automatic pushFrame(input logic [7:0] hdr, input logic [7:0] cks);
    esperado.push_back(hdr);
    esperado.push_back(8'h5C);
    esperado.push_back(8'h41);
    esperado.push_back(8'h66);
    esperado.push_back(8'h73);
`ifdef TX_CHECKSUM_EN
    esperado.push_back(cks);
`else
    if (cks == 8'h00) esperado.push_back(FIM_Q + 1);
`endif
    esperado.push_back(FIM_Q);
  endtask

  // One-cycle request; checks ocupado and start-bit latency, optionally changes floor after acceptance.
  task automatic aceitar(input logic [1:0] novoAndar);
    @(negedge clock);
    bus.enviar = 1'b1;
    @(negedge clock);
    bus.enviar = 1'b0;
    bus.andar_atual = novoAndar;
    checkVal("ocupado_after_accept", bus.ocupado, 1);
    checkVal("tx_high_k", bus.TX, 1);
    @(negedge clock);
    checkVal("tx_high_k1", bus.TX, 1);
    @(negedge clock);
    checkVal("tx_start_k2", bus.TX, 0);
  endtask

  task automatic esperaFim(output int quedas);
    int n;
    quedas = 0;
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (bus.pronto === 1'b1) break;
      if (bus.ocupado !== 1'b1) quedas++;
      if (n > 800) begin
        checks++; errors++;
        $display("FAIL frame_timeout: got no pronto after %0d cycles expected pronto", n);
        break;
      end
    end
  endtask

  task automatic esperaBytes(input int alvo);
    int n;
    n = 0;
    while (bytesDecoded < alvo) begin
      @(negedge clock);
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL byte_timeout: got %0d bytes expected %0d", bytesDecoded, alvo);
        break;
      end
    end
  endtask

  task automatic ocioso(input int ciclos);
    repeat (ciclos) @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : estimulo
    int quedas, p0, b0, ruim;
    reset = 1'b1;
    bus.enviar = 1'b0;
    bus.andar_atual = 2'd2;
    for (int i = 0; i < 16; i++) begin tipoMem[i] = 2'b00; destinoMem[i] = 2'b00; end
    tipoMem[0] = 2'b01; destinoMem[0] = 2'b11;
    tipoMem[1] = 2'b00; destinoMem[1] = 2'b00;
    tipoMem[2] = 2'b10; destinoMem[2] = 2'b01;
    tipoMem[3] = 2'b11; destinoMem[3] = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // reset idle
    checkVal("reset_db_estado", bus.db_estado, 0);
    ruim = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus.TX !== 1'b1 || bus.ocupado !== 1'b0 || bus.slot_addr !== 4'd0 || bus.pronto !== 1'b0) ruim++;
    end
    checkVal("reset_idle_cycles_bad", ruim, 0);

    // basic frame
    p0 = prontoCount;
    pushFrame(8'hC2, 8'hCA);
    aceitar(2'd2);
    esperaFim(quedas);
    checkVal("basic_ocupado_drops", quedas, 0);
    ocioso(10);
    checkVal("basic_queue_left", esperado.size(), 0);
    checkVal("basic_pronto_count", prontoCount - p0, 1);

    // request while busy is ignored
    p0 = prontoCount;
    b0 = bytesDecoded;
    pushFrame(8'hC2, 8'hCA);
    aceitar(2'd2);
    esperaBytes(b0 + 2);
    ocioso(20);
    bus.enviar = 1'b1;
    @(negedge clock);
    bus.enviar = 1'b0;
    esperaFim(quedas);
    checkVal("busy_ocupado_drops", quedas, 0);
    ocioso(150);
    checkVal("busy_pronto_count", prontoCount - p0, 1);
    checkVal("busy_byte_count", bytesDecoded - b0, NBYTES);
    checkVal("busy_queue_left", esperado.size(), 0);

    // enviar held across pronto starts a second frame
    p0 = prontoCount;
    pushFrame(8'hC2, 8'hCA);
    pushFrame(8'hC2, 8'hCA);
    @(negedge clock);
    bus.enviar = 1'b1;
    esperaFim(quedas);
    checkVal("held_ocupado_drops", quedas, 0);
    @(negedge clock);
    checkVal("held_gap_ocupado_low", bus.ocupado, 0);
    @(negedge clock);
    checkVal("held_reaccept", bus.ocupado, 1);
    bus.enviar = 1'b0;
    esperaFim(quedas);
    ocioso(10);
    checkVal("held_pronto_count", prontoCount - p0, 2);
    checkVal("held_queue_left", esperado.size(), 0);

    // reset during slot byte 1
    p0 = prontoCount;
    b0 = bytesDecoded;
    pushFrame(8'hC2, 8'hCA);
    aceitar(2'd2);
    esperaBytes(b0 + 1);
    ocioso(10);
    reset = 1'b1;
    esperado.delete();
    @(negedge clock);
    checkVal("midreset_tx_high", bus.TX, 1);
    checkVal("midreset_ocupado", bus.ocupado, 0);
    @(negedge clock);
    reset = 1'b0;
    ocioso(100);
    checkVal("midreset_no_pronto", prontoCount - p0, 0);
    pushFrame(8'hC2, 8'hCA);
    aceitar(2'd2);
    esperaFim(quedas);
    ocioso(10);
    checkVal("midreset_fresh_pronto", prontoCount - p0, 1);
    checkVal("midreset_queue_left", esperado.size(), 0);

    // floor change after acceptance does not reach the header; then floor 1
    pushFrame(8'hC2, 8'hCA);
    aceitar(2'd3);
    esperaFim(quedas);
    ocioso(5);
    bus.andar_atual = 2'd1;
    pushFrame(8'hC1, 8'hC9);
    aceitar(2'd1);
    esperaFim(quedas);
    ocioso(10);
    checkVal("floor_queue_left", esperado.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_relatorio_elevador.md
# tx_relatorio_elevador

Serial status reporter for the cargo elevator. It is the transmit end of the 8N1 link whose receive side carries the requests. On a request pulse it sends one frame over `TX`:

- a header byte with the current floor;
- one byte per slot of the elevator-contents memory, read through `slot_addr`.

It sits beside the contents RAM and the UART receiver in the datapath and drives the board TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz, 115200 baud).
- `N_SLOTS`, 4: number of content slots reported, 1..16.

Ports:
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enviar` in 1: start-report request, level-sampled each cycle while idle.
- `andar_atual` in 2: current floor, sampled when a request is accepted.
- `slot_tipo` in 2: object type of the addressed slot (00 means empty).
- `slot_destino` in 2: destination floor of the addressed slot.
- `slot_addr` out 4: slot address presented to the contents RAM.
- `TX` out 1: serial line; idles high.
- `ocupado` out 1: high from request acceptance until frame end.
- `pronto` out 1: one-cycle pulse when the frame completes.
- `db_estado` out 4: FSM state encoding, for debug.

## Operation
- Byte layout mirrors the receiver, with the 2 MSBs used as a marker:
  - header = {2'b11, 4'b0000, andar}
  - slot byte i = {2'b01, tipo, destino, i[1:0]}
- Empty slots (tipo 00) are still sent.
- Every byte is framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- FSM states: REPOUSO, CABECALHO, PREP_SLOT, CARREGA_SLOT, ESPERA_TX, CHECKSUM (present only with the macro), FIM.
  - REPOUSO:
    - With `enviar`=1: latch `andar_atual`, clear the slot counter, set `ocupado`, go to CABECALHO.
  - CABECALHO:
    - Load the header into the UART and pulse its start.
    - Go to ESPERA_TX.
  - PREP_SLOT:
    - Drive `slot_addr`=i.
    - Go to CARREGA_SLOT.
    - RAM read latency of 0 or 1 cycle is therefore tolerated.
  - CARREGA_SLOT:
    - Sample `slot_tipo` and `slot_destino`, build the slot byte, pulse the UART start.
    - Go to ESPERA_TX.
  - ESPERA_TX, on UART done:
    - If slots remain (i < `N_SLOTS`): go to PREP_SLOT.
    - Otherwise: go to CHECKSUM if enabled, else FIM.
  - FIM:
    - Pulse `pronto`, clear `ocupado`, return to REPOUSO.
- `enviar` while `ocupado`=1 is ignored and not queued.
- The slot counter is 5 bits. It compares against `N_SLOTS` without wrap; `slot_addr` = counter[3:0].
- `andar_atual` changes mid-frame do not affect the header. Slot data is sampled live per slot.

## Timing
- Reset values:
  - `TX`=1, `ocupado`=0, `pronto`=0, `slot_addr`=0, `db_estado`=REPOUSO.
  - UART idle, checksum accumulator 0.
- Reset mid-frame:
  - Frame abandoned; `TX` is high the cycle after the reset edge.
  - No `pronto` pulse.
- Start-bit latency:
  - Acceptance edge k, where `enviar` is sampled high.
  - `ocupado` is high after edge k.
  - `TX` goes low after edge k+2.
- Bit duration: each bit, including stop, is held exactly `CLKS_PER_BIT` cycles.
- Inter-byte gap: idle-high time between the end of one stop bit and the next start bit is at most 3 cycles.
- Frame end:
  - `pronto` is high for the single cycle after the last stop bit's final cycle.
  - `ocupado` falls on the same edge.
  - A new `enviar` is accepted from the following cycle.
- Frame length: (1 + `N_SLOTS` [+1]) × 10 × `CLKS_PER_BIT` cycles, plus the gaps.

## Configuration
- `TX_CHECKSUM_EN` defined:
  - After the last slot byte, send one extra byte: the XOR of all previously sent bytes in the frame, header included.
  - The accumulator is cleared on acceptance.
- `TX_CHECKSUM_EN` undefined:
  - The frame ends after the last slot byte.
  - The CHECKSUM state and accumulator are absent.

## Structure
- Shared package / include holds:
  - marker constants `MARCA_CABECALHO`=2'b11 and `MARCA_SLOT`=2'b01;
  - the FSM state encodings;
  - the default baud constant.
- Sub-module `tx_serial_8N1`:
  - ports: `clock`, `reset`, `partida`, `dados[7:0]`, `saida_serial`, `pronto`;
  - has its own bit-timer counter and bit index;
  - pairs 1:1 with `rx_serial_8N1`.
- The report FSM and the byte builder live in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset idle: after reset, `TX`=1, `ocupado`=0, `slot_addr`=0 for 50 cycles with `enviar`=0.
- Basic frame, checksum on:
  - Stimulus: `andar`=2; slots (01,11), (00,00), (10,01), (11,00); `enviar` pulse.
  - Decoded bytes: C2, 5C, 41, 66, 73, CA.
  - `pronto` pulses once.
  - First `TX` low 2 cycles after acceptance; each bit is 4 cycles.
- Checksum off: same stimulus gives exactly 5 bytes (C2 5C 41 66 73), then `pronto`.
- Busy request:
  - Pulse `enviar` during the third byte.
  - Only one frame is sent; `ocupado` stays high continuously.
  - The second frame starts only if `enviar` is held after `pronto`.
- Mid-frame reset:
  - Assert `reset` during slot byte 1.
  - `TX`=1 next cycle, no `pronto`.
  - A fresh `enviar` then yields a complete correct frame starting with C2.
- Floor latch: change `andar_atual` 2→3 one cycle after acceptance; header is still C2.
